dot_update_queue: RTL and testbench

- Sits between the processor's dot-write port and the VGA display controller's dot update inputs (dotWren, is_Yloc, dotID, dotLoc).
- Buffers processor coordinate writes in a FIFO and releases them only at frame boundaries, on the rising edge of the controller's screenEnd. Dots therefore never move mid-frame (no tearing).
- Stretches each released write across HOLD_CYCLES system clocks so the controller's 25 MHz domain (clk/4) captures every write exactly once.
- Reports frame completion and overflow back to the processor.

---
 rtl/dot_update_queue_pkg.sv | 36 +++
 rtl/dot_update_queue_sync_fifo.sv | 49 ++++
 rtl/dot_update_queue.sv | 156 +++++++++++++++
 tb/tb_dot_update_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_update_queue_pkg.sv
// rtl/dot_update_queue_pkg.sv - shared entry layout, video limits and FSM states
//
// Purpose: definitions shared by dot_update_queue and its FIFO.
//   - VIDEO_WIDTH / VIDEO_HEIGHT and the derived default coordinate limits
//   - entry layout: {is_y, id[ID_W-1:0], loc[LOC_W-1:0]}, is_y in the MSB
//   - drain FSM state encodings
//   - helpers for the id field width and coordinate clamping
package dot_update_queue_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int X_MAX_DEF    = VIDEO_WIDTH - 1;
  localparam int Y_MAX_DEF    = VIDEO_HEIGHT - 1;

  // Coordinates are stored in 10 bits; both limits fit.
  localparam int LOC_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dq_state_t;

  // Width of the stored id field; never zero so the entry always has a slice.
  function automatic int id_width(input int num_dots);
    return (num_dots > 1) ? $clog2(num_dots) : 1;
  endfunction

  // Saturate a full 32-bit coordinate to lim, then keep the low LOC_W bits.
  function automatic logic [LOC_W-1:0] clamp_loc(input logic [31:0] loc,
                                                 input logic [31:0] lim);
    return (loc > lim) ? lim[LOC_W-1:0] : loc[LOC_W-1:0];
  endfunction

endpackage

// File: rtl/dot_update_queue_sync_fifo.sv
// rtl/dot_update_queue_sync_fifo.sv - parameterised register FIFO
//
// Purpose: single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (pointers only)
//   push, din   write strobe and data; caller guarantees not full unless popping
//   pop, dout   read strobe and current head entry
//   full, empty, count  occupancy derived from the pointer difference
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra bit so full and empty differ; they wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dot_update_queue.sv
// rtl/dot_update_queue.sv - frame-synchronised dot coordinate write queue
//
// Purpose: buffers processor dot writes and releases them to the VGA
// controller only after a rising edge of screenEnd, stretching each write
// over HOLD_CYCLES clocks so the slower display domain sees it once.
// Ports:
//   clk, reset                         system clock, async active-high reset
//   cpu_wren, cpu_is_y, cpu_id, cpu_loc processor write port
//   cpu_full                           FIFO full
//   screenEnd                          frame-boundary level from timing gen
//   dotWren, is_Yloc, dotID, dotLoc    write port to the display controller
//   frame_done                         one-cycle pulse when a drain ends
//   overflow, bad_id                   sticky error flags
module dot_update_queue
  import dot_update_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int NUM_DOTS    = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wren,
  input  logic        cpu_is_y,
  input  logic [31:0] cpu_id,
  input  logic [31:0] cpu_loc,
  output logic        cpu_full,
  input  logic        screenEnd,
  output logic        dotWren,
  output logic        is_Yloc,
  output logic [31:0] dotID,
  output logic [31:0] dotLoc,
  output logic        frame_done,
  output logic        overflow,
  output logic        bad_id
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ID_W    = id_width(NUM_DOTS);
  localparam int ENTRY_W = 1 + ID_W + LOC_W;
  localparam int HC_W    = $clog2(HOLD_CYCLES);

  logic               id_ok;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic [AW:0]        budget;
  logic [LOC_W-1:0]   loc_clamped;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic               se_q;
  logic               start;
  dq_state_t          state;
  logic [HC_W-1:0]    hold_cnt;

  assign id_ok       = (cpu_id < 32'(NUM_DOTS));
  assign loc_clamped = clamp_loc(cpu_loc, cpu_is_y ? 32'(Y_MAX) : 32'(X_MAX));
  assign push_entry  = {cpu_is_y, cpu_id[ID_W-1:0], loc_clamped};

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign pop      = (state == ST_LOAD) && !fifo_empty;
  assign push     = cpu_wren && id_ok && (!fifo_full || pop);
  assign cpu_full = fifo_full;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) se_q <= 1'b0;
    else       se_q <= screenEnd;
  end

  assign start = screenEnd & ~se_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      bad_id   <= 1'b0;
    end else begin
      if (cpu_wren && !id_ok)                      bad_id   <= 1'b1;
      if (cpu_wren && id_ok && fifo_full && !pop)  overflow <= 1'b1;
    end
  end

  // The budget is latched at the frame edge so later pushes wait a frame.
  // The LOAD cycle doubles as the one-clock low gap between writes, and the
  // DONE cycle provides it after the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      budget     <= '0;
      hold_cnt   <= '0;
      dotWren    <= 1'b0;
      is_Yloc    <= 1'b0;
      dotID      <= '0;
      dotLoc     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            budget <= fifo_count;
            if (fifo_count == '0) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          is_Yloc  <= head[ENTRY_W-1];
          dotID    <= 32'(head[LOC_W +: ID_W]);
          dotLoc   <= 32'(head[LOC_W-1:0]);
          dotWren  <= 1'b1;
          hold_cnt <= '0;
          budget   <= budget - 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
            dotWren <= 1'b0;
            if (budget != '0) begin
              state <= ST_LOAD;
            end else begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_update_queue.sv
// tb/tb_dot_update_queue.sv - self-checking bench for dot_update_queue
module tb_dot_update_queue;

  localparam int DEPTH    = 16;
  localparam int NUM_DOTS = 8;
  localparam int HOLD     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wren;
  logic        cpu_is_y;
  logic [31:0] cpu_id;
  logic [31:0] cpu_loc;
  logic        cpu_full;
  logic        screenEnd;
  logic        dotWren;
  logic        is_Yloc;
  logic [31:0] dotID;
  logic [31:0] dotLoc;
  logic        frame_done;
  logic        overflow;
  logic        bad_id;

  always #5 clk = ~clk;

  dot_update_queue dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_wren   (cpu_wren),
    .cpu_is_y   (cpu_is_y),
    .cpu_id     (cpu_id),
    .cpu_loc    (cpu_loc),
    .cpu_full   (cpu_full),
    .screenEnd  (screenEnd),
    .dotWren    (dotWren),
    .is_Yloc    (is_Yloc),
    .dotID      (dotID),
    .dotLoc     (dotLoc),
    .frame_done (frame_done),
    .overflow   (overflow),
    .bad_id     (bad_id)
  );

  typedef struct { logic is_y; logic [31:0] id; logic [31:0] loc; } ent_t;
  typedef struct { logic is_y; logic [31:0] id; logic [31:0] loc; int hi; int gap; } obs_t;
  typedef struct { logic is_y; logic [31:0] id; logic [31:0] loc; logic [31:0] exp_loc; } vec_t;

  ent_t exp_fifo[$];
  obs_t obs_q[$];
  obs_t cur;
  bit   in_wr;
  int   low_run;
  bit   exp_ovf;
  bit   exp_bad;
  int   checks   = 0;
  int   errors   = 0;
  int   fd_cnt   = 0;
  int   stab_err = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records every write seen on the display port with its high length and
  // the number of low cycles before it.
  initial begin
    in_wr   = 1'b0;
    low_run = 1000;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_wr   = 1'b0;
        low_run = 1000;
      end else begin
        if (frame_done) fd_cnt++;
        if (dotWren) begin
          if (!in_wr) begin
            cur.is_y = is_Yloc;
            cur.id   = dotID;
            cur.loc  = dotLoc;
            cur.hi   = 1;
            cur.gap  = low_run;
            in_wr    = 1'b1;
          end else begin
            cur.hi++;
            if ({is_Yloc, dotID, dotLoc} != {cur.is_y, cur.id, cur.loc}) stab_err++;
          end
        end else begin
          if (in_wr) begin
            obs_q.push_back(cur);
            in_wr   = 1'b0;
            low_run = 0;
          end
          low_run++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One-cycle processor write; the model applies the queue rules directly.
  task automatic push(input logic y, input logic [31:0] id, input logic [31:0] loc,
                      input bit force_ok);
    ent_t e;
    logic [31:0] lim;
    cpu_wren = 1'b1;
    cpu_is_y = y;
    cpu_id   = id;
    cpu_loc  = loc;
    if (id >= NUM_DOTS) begin
      exp_bad = 1'b1;
    end else if (!force_ok && exp_fifo.size() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      lim    = y ? 32'd479 : 32'd639;
      e.is_y = y;
      e.id   = id;
      e.loc  = (loc > lim) ? lim : loc;
      exp_fifo.push_back(e);
    end
    @(posedge clk); #1;
    cpu_wren = 1'b0;
  endtask

  // Raise screenEnd, wait for the drain, hold high for hi_cycles in total,
  // then compare everything released against the model's snapshot.
  task automatic run_frame(input int hi_cycles, output int o0);
    ent_t drain[$];
    int   f0;
    int   cyc;
    int   lat;
    drain = exp_fifo;
    exp_fifo.delete();
    o0  = obs_q.size();
    f0  = fd_cnt;
    cyc = 0;
    lat = -1;
    screenEnd = 1'b1;
    while (fd_cnt == f0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (dotWren && lat < 0) lat = cyc;
    end
    while (cyc < hi_cycles) begin
      @(posedge clk); #1;
      cyc++;
    end
    screenEnd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("frame_done_pulses", 32'(fd_cnt - f0), 32'd1);
    chk("write_count", 32'(obs_q.size() - o0), 32'(drain.size()));
    if (drain.size() > 0) begin
      chk("first_write_latency", 32'(lat), 32'd2);
      chk("dotLoc_held_after", dotLoc, drain[drain.size()-1].loc);
      chk("dotWren_low_after", 32'(dotWren), 32'd0);
    end
    for (int i = 0; i < drain.size() && o0 + i < obs_q.size(); i++) begin
      chk("w_is_y", 32'(obs_q[o0+i].is_y), 32'(drain[i].is_y));
      chk("w_id", obs_q[o0+i].id, drain[i].id);
      chk("w_loc", obs_q[o0+i].loc, drain[i].loc);
      chk("w_hold_len", 32'(obs_q[o0+i].hi), 32'(HOLD));
      if (i > 0) chk("w_gap_len", 32'(obs_q[o0+i].gap), 32'd1);
    end
  endtask

  initial begin
    int o0;
    int n;
    int n_hi;
    int cyc;
    logic prev;
    logic y;
    logic [31:0] rid;
    logic [31:0] rloc;

    tbl[0] = '{1'b0, 32'd2, 32'd100, 32'd100};
    tbl[1] = '{1'b1, 32'd2, 32'd50, 32'd50};
    tbl[2] = '{1'b0, 32'd5, 32'd700, 32'd639};
    tbl[3] = '{1'b0, 32'd7, 32'd639, 32'd639};
    tbl[4] = '{1'b0, 32'd0, 32'd640, 32'd639};
    tbl[5] = '{1'b1, 32'd1, 32'd479, 32'd479};
    tbl[6] = '{1'b1, 32'd3, 32'd480, 32'd479};
    tbl[7] = '{1'b0, 32'd4, 32'hFFFF_FFFF, 32'd639};
    tbl[8] = '{1'b1, 32'd6, 32'h0000_0400, 32'd479};
    tbl[9] = '{1'b0, 32'd1, 32'd0, 32'd0};

    reset = 1'b1; cpu_wren = 1'b0; cpu_is_y = 1'b0; cpu_id = '0; cpu_loc = '0;
    screenEnd = 1'b0; exp_ovf = 1'b0; exp_bad = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_dotWren", 32'(dotWren), 32'd0);
    chk("rst_is_Yloc", 32'(is_Yloc), 32'd0);
    chk("rst_dotID", dotID, 32'd0);
    chk("rst_dotLoc", dotLoc, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bad_id", 32'(bad_id), 32'd0);
    chk("rst_cpu_full", 32'(cpu_full), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic three-write frame, then the clamp boundary vectors.
    for (int i = 0; i < 3; i++) push(tbl[i].is_y, tbl[i].id, tbl[i].loc, 1'b0);
    run_frame(800, o0);
    for (int i = 0; i < 3; i++)
      chk("tbl_loc", obs_q[o0+i].loc, tbl[i].exp_loc);
    for (int i = 3; i < 10; i++) push(tbl[i].is_y, tbl[i].id, tbl[i].loc, 1'b0);
    run_frame(50, o0);
    for (int i = 3; i < 10; i++) begin
      chk("tbl_id", obs_q[o0+i-3].id, tbl[i].id);
      chk("tbl_loc", obs_q[o0+i-3].loc, tbl[i].exp_loc);
    end

    // Fill to full, then one more.
    for (int k = 0; k < 16; k++) begin
      push(k[0], 32'(k % 8), 32'(k * 45), 1'b0);
      if (k == 14) chk("not_full_at_15", 32'(cpu_full), 32'd0);
    end
    chk("full_at_16", 32'(cpu_full), 32'd1);
    chk("no_overflow_at_16", 32'(overflow), 32'd0);
    push(1'b0, 32'd1, 32'd5, 1'b0);
    chk("overflow_at_17", 32'(overflow), 32'd1);
    run_frame(30, o0);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    chk("not_full_after_drain", 32'(cpu_full), 32'd0);

    // Rejected ids.
    push(1'b0, 32'd8, 32'd10, 1'b0);
    chk("bad_id_set", 32'(bad_id), 32'd1);
    push(1'b1, 32'h8000_0003, 32'd10, 1'b0);
    run_frame(20, o0);
    chk("bad_id_sticky", 32'(bad_id), 32'd1);

    // Pushes during a drain wait for the next frame.
    for (int k = 0; k < 4; k++) push(1'b1, 32'(k + 1), 32'(k * 100), 1'b0);
    fork
      run_frame(40, o0);
      begin
        repeat (7) @(posedge clk); #1;
        push(1'b1, 32'd3, 32'd200, 1'b0);
        push(1'b0, 32'd4, 32'd300, 1'b0);
      end
    join
    run_frame(20, o0);

    // Reset during the second hold of a four-entry drain.
    for (int k = 0; k < 4; k++) push(1'b0, 32'(k), 32'(k + 10), 1'b0);
    screenEnd = 1'b1;
    n_hi = 0; prev = 1'b0; cyc = 0;
    while (n_hi < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (dotWren && !prev) n_hi++;
      prev = dotWren;
    end
    chk("reached_second_hold", 32'(n_hi), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_mid_dotWren", 32'(dotWren), 32'd0);
    chk("rst_mid_dotLoc", dotLoc, 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    chk("rst_mid_bad_id", 32'(bad_id), 32'd0);
    exp_fifo.delete(); exp_ovf = 1'b0; exp_bad = 1'b0;
    screenEnd = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    obs_q.delete();
    run_frame(20, o0);

    // A long screenEnd level gives one drain only.
    push(1'b0, 32'd6, 32'd11, 1'b0);
    push(1'b1, 32'd7, 32'd22, 1'b0);
    run_frame(1600, o0);

    // Push and pop in the same cycle at full count.
    for (int k = 0; k < 16; k++) push(k[1], 32'(7 - (k % 8)), 32'(k * 30), 1'b0);
    fork
      run_frame(30, o0);
      begin
        @(posedge clk); #1;
        push(1'b1, 32'd6, 32'd123, 1'b1);
        chk("full_kept_pushpop", 32'(cpu_full), 32'd1);
        chk("no_overflow_pushpop", 32'(overflow), 32'd0);
      end
    join
    run_frame(20, o0);

    // Randomized rounds against the model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) begin
        y    = 1'($urandom_range(0, 1));
        rid  = $urandom_range(0, 9);
        rloc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1100);
        push(y, rid, rloc, 1'b0);
      end
      run_frame(20, o0);
      chk("overflow_model", 32'(overflow), 32'(exp_ovf));
      chk("bad_id_model", 32'(bad_id), 32'(exp_bad));
    end

    chk("outputs_stable_in_hold", 32'(stab_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
